result_display_latch: RTL



---
 rtl/result_display_latch.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/result_display_latch.sv
// Latches the ALU result on a debounced button press and shows it on a
// 4-digit multiplexed 7-segment display (function code, sign, decimal magnitude).
module result_display_latch #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REFRESH_CYCLES  = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] o_in,
    input  logic       v_in,
    input  logic       c_in,
    input  logic [2:0] fxn,
    input  logic       btn_capture,
    output logic [5:0] result_q,
    output logic       valid,
    output logic       led_v,
    output logic       led_c,
    output logic [3:0] an,
    output logic [6:0] seg
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(REFRESH_CYCLES + 1);

    localparam logic [3:0] CODE_DASH  = 4'd10;
    localparam logic [3:0] CODE_BLANK = 4'd11;

    logic          sync1;
    logic          sync2;
    logic          deb_level;
    logic [DW-1:0] deb_cnt;
    logic          cap_pulse;
    logic [2:0]    fxn_q;
    logic [RW-1:0] ref_cnt;
    logic [1:0]    digit_idx;

    logic       deb_done;
    logic [6:0] sext;
    logic [6:0] mag;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [3:0] digit_code;
    logic [3:0] an_next;
    logic [6:0] seg_next;

    assign deb_done = (sync2 != deb_level) && (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));

    // Button path: synchronizer, debounce counter and rising-edge pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            deb_level <= 1'b0;
            deb_cnt   <= '0;
            cap_pulse <= 1'b0;
        end else begin
            sync1     <= btn_capture;
            sync2     <= sync1;
            cap_pulse <= deb_done && !deb_level;
            if (sync2 == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_done) begin
                deb_level <= ~deb_level;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // Capture; flags only carry meaning for the two arithmetic functions.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            fxn_q    <= '0;
            valid    <= 1'b0;
            led_v    <= 1'b0;
            led_c    <= 1'b0;
        end else if (cap_pulse) begin
            result_q <= o_in;
            fxn_q    <= fxn;
            valid    <= 1'b1;
            if (fxn[2:1] == 2'b11) begin
                led_v <= v_in;
                led_c <= c_in;
            end else begin
                led_v <= 1'b0;
                led_c <= 1'b0;
            end
        end
    end

    // Magnitude of the two's complement result and its decimal split.
    always_comb begin
        sext = {result_q[5], result_q};
        mag  = result_q[5] ? (7'd0 - sext) : sext;
        tens = 4'd0;
        ones = mag[3:0];
        if (mag >= 7'd30) begin
            tens = 4'd3;
            ones = 4'(mag - 7'd30);
        end else if (mag >= 7'd20) begin
            tens = 4'd2;
            ones = 4'(mag - 7'd20);
        end else if (mag >= 7'd10) begin
            tens = 4'd1;
            ones = 4'(mag - 7'd10);
        end
    end

    function automatic logic [6:0] seg_of(input logic [3:0] code);
        case (code)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            4'd10:   seg_of = 7'b0111111;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        digit_code = CODE_DASH;
        an_next    = 4'b1110;
        case (digit_idx)
            2'd0: begin
                an_next = 4'b1110;
                if (valid) digit_code = ones;
            end
            2'd1: begin
                an_next = 4'b1101;
                if (valid) digit_code = (tens == 4'd0) ? CODE_BLANK : tens;
            end
            2'd2: begin
                an_next = 4'b1011;
                if (valid) digit_code = result_q[5] ? CODE_DASH : CODE_BLANK;
            end
            default: begin
                an_next = 4'b0111;
                if (valid) digit_code = {1'b0, fxn_q};
            end
        endcase
        seg_next = seg_of(digit_code);
    end

    // Refresh: an and seg come from the same digit index in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ref_cnt   <= '0;
            digit_idx <= 2'd0;
            an        <= 4'b1111;
            seg       <= 7'b1111111;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            if (ref_cnt == RW'(REFRESH_CYCLES - 1)) begin
                ref_cnt   <= '0;
                digit_idx <= digit_idx + 2'd1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end
        end
    end
endmodule
